alsu_arbiter: RTL and testbench

Shares one ALSU instance (registered inputs, registered 6-bit out) between two requesters.
- Round-robin arbitration picks one requester at a time.
- The granted command is screened for illegal combinations, driven to the ALSU for exactly one cycle, and the result is captured after a fixed pipeline latency.
- The result is returned on a valid/ready response channel tagged with the requester id.
- The block sits between the bus/host logic and the ALSU datapath.

---
 rtl/alsu_ctrl_pkg.sv | 48 ++++
 rtl/alsu_rr_arb2.sv | 38 +++
 rtl/alsu_arbiter.sv | 157 +++++++++++++++
 tb/tb_alsu_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_ctrl_pkg.sv
// Shared command layout, opcodes, FSM encoding and the legality screen for the
// ALSU arbiter.
package alsu_ctrl_pkg;

  localparam int CMD_W = 16;

  // Command layout, MSB first: opcode, A, B, cin, serial_in, red_op_A,
  // red_op_B, bypass_A, bypass_B, direction.
  localparam int OPC_LSB   = 13;
  localparam int OPC_W     = 3;
  localparam int A_LSB     = 10;
  localparam int B_LSB     = 7;
  localparam int OPD_W     = 3;
  localparam int CIN_BIT   = 6;
  localparam int SER_BIT   = 5;
  localparam int RED_A_BIT = 4;
  localparam int RED_B_BIT = 3;
  localparam int BYP_A_BIT = 2;
  localparam int BYP_B_BIT = 1;
  localparam int DIR_BIT   = 0;

  localparam logic [OPC_W-1:0] OP_AND   = 3'd0;
  localparam logic [OPC_W-1:0] OP_XOR   = 3'd1;
  localparam logic [OPC_W-1:0] OP_ADD   = 3'd2;
  localparam logic [OPC_W-1:0] OP_MUL   = 3'd3;
  localparam logic [OPC_W-1:0] OP_SHIFT = 3'd4;
  localparam logic [OPC_W-1:0] OP_ROT   = 3'd5;

  localparam logic [CMD_W-1:0] IDLE_CMD = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Opcodes 6/7 do not exist; reduction flags are only meaningful for AND/XOR.
  function automatic logic is_illegal(input logic [CMD_W-1:0] cmd);
    logic [OPC_W-1:0] opc;
    logic             red;
    opc = cmd[OPC_LSB +: OPC_W];
    red = cmd[RED_A_BIT] | cmd[RED_B_BIT];
    return (opc == 3'd6) || (opc == 3'd7) ||
           (red && (opc != OP_AND) && (opc != OP_XOR));
  endfunction

endpackage

// File: rtl/alsu_rr_arb2.sv
// Two-requester round-robin grant. On a tie the requester that did not win
// last time is granted; a grant is always a handshake since it implies valid.
module alsu_rr_arb2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic valid0_i,
  input  logic valid1_i,
  output logic gnt0_o,
  output logic gnt1_o,
  output logic gnt_id_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_id_o = (valid0_i && valid1_i) ? ~last_q : valid1_i;
    gnt0_o   = en_i && valid0_i && !gnt_id_o;
    gnt1_o   = en_i && valid1_i &&  gnt_id_o;
    last_d   = last_q;
    if (gnt0_o) begin
      last_d = 1'b0;
    end else if (gnt1_o) begin
      last_d = 1'b1;
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alsu_arbiter.sv
// Shares one pipelined ALSU between two requesters: round-robin grant, illegal
// command screening, one-cycle issue, fixed-latency capture, tagged response.
module alsu_arbiter
  import alsu_ctrl_pkg::*;
#(
  parameter int LAT   = 2,  // issue-to-result latency, 1..15
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [CMD_W-1:0] req0_cmd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [CMD_W-1:0] req1_cmd,
  output logic [CMD_W-1:0] alsu_cmd,
  input  logic [5:0]       alsu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [5:0]       rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output state_e           dbg_state
);

  localparam logic [3:0] WAIT_INIT = 4'(LAT - 1);

  // Valid/ready: a transfer happens on a rising edge where both are high.
  // Producers hold valid and payload stable until that edge; ready may depend
  // combinationally on valid, never the other way round.

  state_e           state_q, state_d;
  logic [CMD_W-1:0] alsu_cmd_q, alsu_cmd_d;
  logic             id_q, id_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [5:0]       rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic             arb_en;
  logic             gnt0, gnt1, gnt_id;
  logic             accept;
  logic [CMD_W-1:0] sel_cmd;
  logic             sel_illegal;

  alsu_rr_arb2 u_arb (
    .clk_i    (clk),
    .rst_ni   (rst),
    .en_i     (arb_en),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1),
    .gnt_id_o (gnt_id)
  );

  assign accept      = req0_ready | req1_ready;
  assign sel_cmd     = gnt_id ? req1_cmd : req0_cmd;
  assign sel_illegal = is_illegal(sel_cmd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = sel_illegal ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    arb_en     = (state_q == ST_IDLE);
    req0_ready = gnt0;
    req1_ready = gnt1;
    busy       = (state_q != ST_IDLE);
    rsp_valid  = (state_q == ST_RESP);
  end

  // alsu_cmd is loaded on acceptance so it is non-idle exactly during ISSUE.
  always_comb begin
    alsu_cmd_d = IDLE_CMD;
    id_d       = id_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    issued_d   = issued_q;
    err_d      = err_q;
    if (accept) begin
      id_d = gnt_id;
      if (sel_illegal) begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
        err_d      = err_q + CNT_W'(1);
      end else begin
        alsu_cmd_d = sel_cmd;
      end
    end
    case (state_q)
      ST_ISSUE: begin
        issued_d = issued_q + CNT_W'(1);
        cnt_d    = WAIT_INIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d = alsu_out;
          rsp_err_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alsu_cmd_q <= IDLE_CMD;
      id_q       <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      issued_q   <= '0;
      err_q      <= '0;
    end else begin
      alsu_cmd_q <= alsu_cmd_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      issued_q   <= issued_d;
      err_q      <= err_d;
    end
  end

  assign alsu_cmd   = alsu_cmd_q;
  assign rsp_id     = id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign issued_cnt = issued_q;
  assign err_cnt    = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alsu_arbiter.sv
// Self-checking bench for alsu_arbiter with a simple two-register ALSU model
// and a response model derived from the arbitration and legality rules.
module tb_alsu_arbiter;
  import alsu_ctrl_pkg::*;

  localparam int LAT   = 2;
  localparam int CNT_W = 8;
  localparam int TO    = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [CMD_W-1:0] req0_cmd = '0, req1_cmd = '0;
  logic             req0_ready, req1_ready;
  logic [CMD_W-1:0] alsu_cmd;
  logic [5:0]       alsu_out;
  logic             rsp_valid, rsp_id, rsp_err, busy;
  logic             rsp_ready = 1'b0;
  logic [5:0]       rsp_data;
  logic [CNT_W-1:0] issued_cnt, err_cnt;
  state_e           dbg_state;

  int   checks = 0, errors = 0;
  int   exp_issued = 0, exp_err = 0;
  bit   last_grant = 1'b1;
  logic [7:0] exp_q[$];

  alsu_arbiter #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .alsu_cmd(alsu_cmd), .alsu_out(alsu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .issued_cnt(issued_cnt), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ref_alsu(input logic [CMD_W-1:0] c);
    int a, b, ci;
    a  = int'(c[12:10]);
    b  = int'(c[9:7]);
    ci = int'(c[6]);
    case (c[15:13])
      3'd0:    return 6'(a & b);
      3'd1:    return 6'(a ^ b);
      3'd2:    return 6'(a + b + ci);
      3'd3:    return 6'(a * b);
      default: return 6'd0;
    endcase
  endfunction

  function automatic bit ref_illegal(input logic [CMD_W-1:0] c);
    int opc;
    opc = int'(c[15:13]);
    return (opc >= 6) || ((c[4] || c[3]) && opc > 1);
  endfunction

  function automatic logic [7:0] ref_rsp(input bit id, input logic [CMD_W-1:0] c);
    if (ref_illegal(c)) return {id, 1'b1, 6'd0};
    return {id, 1'b0, ref_alsu(c)};
  endfunction

  function automatic logic [CMD_W-1:0] rand_cmd(input bit legal);
    logic [CMD_W-1:0] c;
    c    = CMD_W'($urandom);
    c[0] = 1'b1;
    if (legal) begin
      c[15:13] = 3'($urandom_range(0, 3));
      if (c[15:13] > 3'd1) c[4:3] = 2'b00;
    end
    return c;
  endfunction

  // ALSU stand-in: input register then output register.
  logic [CMD_W-1:0] alsu_in_q  = '0;
  logic [5:0]       alsu_out_q = '0;
  always @(posedge clk) begin
    alsu_in_q  <= alsu_cmd;
    alsu_out_q <= ref_alsu(alsu_in_q);
  end
  assign alsu_out = alsu_out_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TO; i++) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL ready_timeout id=%0d: no ready in %0d cycles, need ready=1", id, TO); end
  endtask

  task automatic wait_rsp(output int n, output int ncmd, output logic [CMD_W-1:0] seen);
    n = 0; ncmd = 0; seen = '0;
    while (n < TO) begin
      if (alsu_cmd !== IDLE_CMD) begin ncmd++; seen = alsu_cmd; end
      if (rsp_valid === 1'b1) break;
      tick();
      n++;
    end
    checks++;
    if (n >= TO) begin errors++; $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, need 1", rsp_valid, n); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if ({rsp_valid, rsp_id, rsp_err, busy} !== 4'b0) begin errors++; $display("FAIL rst_ctrl got=%b exp=0000", {rsp_valid, rsp_id, rsp_err, busy}); end
    checks++; if (rsp_data !== 6'd0) begin errors++; $display("FAIL rst_data got=%0d exp=0", rsp_data); end
    checks++; if (alsu_cmd !== IDLE_CMD) begin errors++; $display("FAIL rst_alsu_cmd got=%h exp=0", alsu_cmd); end
    checks++; if (issued_cnt !== '0 || err_cnt !== '0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", issued_cnt, err_cnt); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    rst = 1'b1;
    tick();
    checks++; if ({req0_ready, req1_ready, busy} !== 3'b0) begin errors++; $display("FAIL idle_after_rst got=%b exp=000", {req0_ready, req1_ready, busy}); end
  endtask

  task automatic test_single();
    logic [CMD_W-1:0] c, seen;
    bit ok;
    int n, ncmd;
    c = {3'd3, 3'd3, 3'd2, 7'b0000001};
    rsp_ready = 1'b1; req0_cmd = c; req0_valid = 1'b1; #1;
    wait_ready(1'b0, ok);
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_r1 got=%b exp=0", req1_ready); end
    tick();
    req0_valid = 1'b0; exp_issued++; last_grant = 1'b0;
    wait_rsp(n, ncmd, seen);
    checks++; if (n !== LAT + 1) begin errors++; $display("FAIL single_lat got=%0d exp=%0d", n, LAT + 1); end
    checks++; if (ncmd !== 1 || seen !== c) begin errors++; $display("FAIL single_cmd got=%0d/%h exp=1/%h", ncmd, seen, c); end
    checks++; if ({rsp_id, rsp_err, rsp_data} !== {1'b0, 1'b0, 6'd6}) begin errors++; $display("FAIL single_rsp got=%b/%b/%0d exp=0/0/6", rsp_id, rsp_err, rsp_data); end
    checks++; if (issued_cnt !== CNT_W'(1)) begin errors++; $display("FAIL single_issued got=%0d exp=1", issued_cnt); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b/%b exp=0/0", rsp_valid, busy); end
  endtask

  task automatic test_alternate();
    logic [CMD_W-1:0] c0, c1, seen;
    logic [7:0] e;
    bit g, exp_g;
    int n, ncmd;
    rsp_ready = 1'b1;
    c0 = rand_cmd(1'b1); c1 = rand_cmd(1'b1);
    req0_cmd = c0; req1_cmd = c1; req0_valid = 1'b1; req1_valid = 1'b1; #1;
    for (int k = 0; k < 8; k++) begin
      int w;
      w = 0;
      while (req0_ready !== 1'b1 && req1_ready !== 1'b1 && w < TO) begin tick(); w++; end
      checks++; if (w >= TO || (req0_ready === 1'b1 && req1_ready === 1'b1)) begin errors++; $display("FAIL alt_ready k=%0d got=%b%b exp=one-hot", k, req1_ready, req0_ready); end
      g = (req1_ready === 1'b1);
      exp_g = ~last_grant;
      checks++; if (g !== exp_g) begin errors++; $display("FAIL alt_grant k=%0d got=%0d exp=%0d", k, g, exp_g); end
      last_grant = exp_g;
      exp_q.push_back(ref_rsp(exp_g, exp_g ? c1 : c0));
      exp_issued++;
      tick();
      if (g) begin c1 = rand_cmd(1'b1); req1_cmd = c1; end
      else   begin c0 = rand_cmd(1'b1); req0_cmd = c0; end
      wait_rsp(n, ncmd, seen);
      e = exp_q.pop_front();
      checks++; if ({rsp_id, rsp_err, rsp_data} !== e) begin errors++; $display("FAIL alt_rsp k=%0d got=%h exp=%h", k, {rsp_id, rsp_err, rsp_data}, e); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_illegal();
    logic [CMD_W-1:0] c, seen;
    bit ok;
    int n, ncmd, iss0;
    iss0 = exp_issued;
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      c = rand_cmd(1'b0);
      if (k == 0) c[15:13] = 3'd6;
      else begin c[15:13] = 3'd2; c[4] = 1'b1; end
      req1_cmd = c; req1_valid = 1'b1; #1;
      wait_ready(1'b1, ok);
      tick();
      req1_valid = 1'b0; exp_err++; last_grant = 1'b1;
      wait_rsp(n, ncmd, seen);
      checks++; if (n !== 0 || ncmd !== 0) begin errors++; $display("FAIL ill_timing k=%0d got=%0d/%0d exp=0/0", k, n, ncmd); end
      checks++; if ({rsp_id, rsp_err, rsp_data} !== {1'b1, 1'b1, 6'd0}) begin errors++; $display("FAIL ill_rsp k=%0d got=%b/%b/%0d exp=1/1/0", k, rsp_id, rsp_err, rsp_data); end
      tick();
    end
    checks++; if (err_cnt !== CNT_W'(exp_err)) begin errors++; $display("FAIL ill_err_cnt got=%0d exp=%0d", err_cnt, exp_err); end
    checks++; if (issued_cnt !== CNT_W'(iss0)) begin errors++; $display("FAIL ill_issued got=%0d exp=%0d", issued_cnt, iss0); end
  endtask

  task automatic test_backpressure();
    logic [CMD_W-1:0] c, seen;
    logic [7:0] e;
    bit ok;
    int n, ncmd;
    c = rand_cmd(1'b1);
    rsp_ready = 1'b0; req0_cmd = c; req0_valid = 1'b1; #1;
    wait_ready(1'b0, ok);
    tick();
    e = ref_rsp(1'b0, c); last_grant = 1'b0; exp_issued++;
    req0_cmd = rand_cmd(1'b1); req1_cmd = rand_cmd(1'b1); req1_valid = 1'b1;
    wait_rsp(n, ncmd, seen);
    checks++; if (n !== LAT + 1) begin errors++; $display("FAIL bp_lat got=%0d exp=%0d", n, LAT + 1); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, e} || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold i=%0d got=v%b %h r%b%b exp=v1 %h r00", i, rsp_valid, {rsp_id, rsp_err, rsp_data}, req1_ready, req0_ready, e);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || req1_ready !== ~last_grant || req0_ready !== last_grant) begin errors++; $display("FAIL bp_resume got=busy%b r%b%b exp=busy0 r%b%b", busy, req1_ready, req0_ready, ~last_grant, last_grant); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [CMD_W-1:0] c, seen;
    logic [7:0] e;
    bit ok, id, ill;
    int n, ncmd, hold;
    for (int k = 0; k < 20; k++) begin
      id = 1'($urandom_range(0, 1));
      c = rand_cmd(1'($urandom_range(0, 1)));
      hold = $urandom_range(0, 3);
      rsp_ready = (hold == 0);
      if (id) begin req1_cmd = c; req1_valid = 1'b1; end
      else    begin req0_cmd = c; req0_valid = 1'b1; end
      #1;
      wait_ready(id, ok);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      ill = ref_illegal(c);
      exp_q.push_back(ref_rsp(id, c));
      if (ill) exp_err++; else exp_issued++;
      last_grant = id;
      wait_rsp(n, ncmd, seen);
      checks++; if (n !== (ill ? 0 : LAT + 1)) begin errors++; $display("FAIL rnd_lat k=%0d got=%0d exp=%0d", k, n, ill ? 0 : LAT + 1); end
      checks++; if (ncmd !== (ill ? 0 : 1) || (!ill && seen !== c)) begin errors++; $display("FAIL rnd_cmd k=%0d got=%0d/%h exp=%0d/%h", k, ncmd, seen, ill ? 0 : 1, c); end
      repeat (hold) tick();
      e = exp_q.pop_front();
      checks++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_err, rsp_data} !== e) begin errors++; $display("FAIL rnd_rsp k=%0d got=v%b %h exp=v1 %h", k, rsp_valid, {rsp_id, rsp_err, rsp_data}, e); end
      rsp_ready = 1'b1;
      tick();
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_done k=%0d got=%b/%b exp=0/0", k, busy, rsp_valid); end
    end
    checks++; if (issued_cnt !== CNT_W'(exp_issued) || err_cnt !== CNT_W'(exp_err)) begin errors++; $display("FAIL rnd_cnt got=%0d/%0d exp=%0d/%0d", issued_cnt, err_cnt, CNT_W'(exp_issued), CNT_W'(exp_err)); end
  endtask

  task automatic test_reset_wait();
    logic [CMD_W-1:0] c;
    bit ok;
    c = rand_cmd(1'b1);
    rsp_ready = 1'b1; req0_cmd = c; req0_valid = 1'b1; #1;
    wait_ready(1'b0, ok);
    tick();
    req0_valid = 1'b0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy_before got=%b exp=1", busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({busy, rsp_valid, rsp_id, rsp_err} !== 4'b0 || rsp_data !== 6'd0) begin errors++; $display("FAIL rw_async_ctrl got=%b/%0d exp=0000/0", {busy, rsp_valid, rsp_id, rsp_err}, rsp_data); end
    checks++; if (alsu_cmd !== IDLE_CMD || issued_cnt !== '0 || err_cnt !== '0) begin errors++; $display("FAIL rw_async_regs got=%h/%0d/%0d exp=0/0/0", alsu_cmd, issued_cnt, err_cnt); end
    exp_issued = 0; exp_err = 0; last_grant = 1'b1;
    tick();
    rst = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rw_no_rsp i=%0d got=%b/%b exp=0/0", i, rsp_valid, busy); end
      tick();
    end
    req0_cmd = rand_cmd(1'b1); req1_cmd = rand_cmd(1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rw_first_grant got=r%b%b exp=r01", req1_ready, req0_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0; #1;
  endtask

  task automatic test_back_to_back();
    logic [CMD_W-1:0] c;
    logic [7:0] e;
    rsp_ready = 1'b1;
    c = rand_cmd(1'b1); req0_cmd = c; req0_valid = 1'b1; #1;
    e = '0;
    for (int k = 0; k < 256; k++) begin
      for (int p = 0; p < LAT + 3; p++) begin
        checks++;
        if (req0_ready !== (p == 0) || busy !== (p != 0) || rsp_valid !== (p == LAT + 2)) begin
          errors++;
          $display("FAIL b2b_phase k=%0d p=%0d got=r%b b%b v%b exp=r%b b%b v%b", k, p, req0_ready, busy, rsp_valid, p == 0, p != 0, p == LAT + 2);
        end
        if (p == 0) begin e = ref_rsp(1'b0, c); exp_issued++; last_grant = 1'b0; end
        if (p == LAT + 2) begin
          checks++; if ({rsp_id, rsp_err, rsp_data} !== e) begin errors++; $display("FAIL b2b_rsp k=%0d got=%h exp=%h", k, {rsp_id, rsp_err, rsp_data}, e); end
        end
        tick();
        if (p == 0) begin c = rand_cmd(1'b1); req0_cmd = c; end
      end
    end
    req0_valid = 1'b0;
    checks++; if (issued_cnt !== CNT_W'(exp_issued)) begin errors++; $display("FAIL b2b_wrap got=%0d exp=%0d", issued_cnt, CNT_W'(exp_issued)); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_illegal();
    test_backpressure();
    test_random();
    test_reset_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
